gb_arbiter: RTL
===============

GB_ARBITER -- requirements
Module: gb_arbiter

Interface
REQ-001 SHALL have parameter AW, default 24, ghostbus address width.
REQ-002 SHALL have parameter DW, default 32, ghostbus data width.
REQ-003 SHALL have parameter READ_DELAY, default 3, cycles from the gb_rstb cycle to a valid gb_rdata; legal range 1..15.
REQ-004 SHALL have port gb_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port gb_rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports req0/req1  input  1  transaction request from requester 0/1.
REQ-007 SHALL have ports we0/we1  input  1  1=write, 0=read; held stable while the matching req is high.
REQ-008 SHALL have ports addr0/addr1  input  AW  and wdata0/wdata1  input  DW; held stable while the matching req is high.
REQ-009 SHALL have ports ack0/ack1  output  1  one-cycle transaction-complete pulse.
REQ-010 SHALL have ports rdata0/rdata1  output  DW  read result, valid in the ack cycle and held until that port's next read ack.
REQ-011 SHALL have ports gb_addr  output  AW  and gb_wdata  output  DW, registered.
REQ-012 SHALL have ports gb_wen  output  1  and gb_rstb  output  1, registered one-cycle strobes.
REQ-013 SHALL have port gb_rdata  input  DW  ghostbus read data.

Function
REQ-014 SHALL implement the FSM states IDLE, XFER, WAIT and ACK; all transitions occur on gb_clk.
REQ-015 IDLE, cycle T: if any req is high, SHALL latch the granted port's we/addr/wdata and go to XFER; otherwise stay in IDLE.
REQ-016 Single request: SHALL grant that port. Both requests: SHALL grant the port not granted last (round-robin via a last_grant register).
REQ-017 XFER, cycle T+1: gb_addr (and gb_wdata on writes) SHALL be valid; exactly one of gb_wen/gb_rstb SHALL be high, for this cycle only.
REQ-018 Write: XFER SHALL go to ACK; ack of the granted port SHALL be high at T+2.
REQ-019 Read: XFER SHALL go to WAIT; a 4-bit counter SHALL count READ_DELAY cycles; gb_rdata SHALL be captured at cycle T+1+READ_DELAY into the granted port's rdata; ack SHALL be high at T+2+READ_DELAY.
REQ-020 ACK SHALL last one cycle, then go to IDLE; req sampled high in IDLE after an ack SHALL start a new transaction.
REQ-021 Only one ack SHALL ever be high at a time; ack of a non-granted port SHALL stay low.
REQ-022 gb_addr/gb_wdata SHALL hold their last driven values outside XFER; gb_wen/gb_rstb SHALL be 0 outside XFER.
REQ-023 A req change during XFER/WAIT/ACK SHALL be ignored until the next IDLE.
REQ-024 rdata of the non-granted port SHALL never change.

Reset
REQ-025 gb_rst SHALL force: state=IDLE, ack0/ack1=0, gb_wen=gb_rstb=0, gb_addr=0, gb_wdata=0, rdata0/rdata1=0, wait counter=0, last_grant=1 (port 0 wins the first contention).
REQ-026 gb_rst asserted mid-transaction SHALL abort it with no ack; the requester reissues.

Configuration
REQ-027 Macro GB_ARBITER_STATS_EN SHALL, when defined, add outputs cnt0/cnt1 (16 bits), each incremented on every ack of its port, wrapping 0xFFFF->0, reset to 0.
REQ-028 Without GB_ARBITER_STATS_EN, cnt0/cnt1 and their counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Reset, then req0 write addr=0x000004, wdata=0x5: gb_wen high exactly at T+1 with gb_addr=0x000004, gb_wdata=0x5; ack0 at T+2; ack1 stays 0.
REQ-030 req1 read addr=0x000020, slave returning 0xD0 at READ_DELAY=3: gb_rstb at T+1; rdata1=0xD0 with ack1 at T+5.
REQ-031 req0 and req1 asserted in the same cycle after reset: port 0 acked first, then port 1; repeated contention alternates 0,1,0,1.
REQ-032 gb_rst pulsed during WAIT of a read: no ack; state IDLE; outputs at reset values; the next request completes normally.
REQ-033 With GB_ARBITER_STATS_EN: 3 port-0 and 2 port-1 transactions -> cnt0=3, cnt1=2; build without the macro also passes REQ-029..REQ-032.

Source files
------------

// File: rtl/gb_arbiter.sv
// Two-port round-robin arbiter in front of a single ghostbus master port.
// Optional per-port ack counters are enabled by defining GB_ARBITER_STATS_EN.
module gb_arbiter #(
    parameter int unsigned AW         = 24,
    parameter int unsigned DW         = 32,
    parameter int unsigned READ_DELAY = 3
) (
    input  logic          gb_clk,
    input  logic          gb_rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    output logic          gb_wen,
    output logic          gb_rstb,
`ifdef GB_ARBITER_STATS_EN
    output logic [15:0]   cnt0,
    output logic [15:0]   cnt1,
`endif
    input  logic [DW-1:0] gb_rdata
);

    typedef enum logic [1:0] {StIdle, StXfer, StWait, StAck} state_e;

    localparam logic [3:0] RdCnt = 4'(READ_DELAY);

    state_e        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic          we_q, we_d;
    logic [3:0]    wait_cnt_q, wait_cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          wen_q, wen_d;
    logic          rstb_q, rstb_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          sel;
    logic          sel_we;

    // Contention goes to the port not served last; a lone request wins outright.
    assign sel    = (req0 && req1) ? ~last_grant_q : req1;
    assign sel_we = sel ? we1 : we0;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        wait_cnt_d   = wait_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wen_d        = 1'b0;
        rstb_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        unique case (state_q)
            StIdle: begin
                wait_cnt_d = 4'd0;
                if (req0 || req1) begin
                    grant_d      = sel;
                    last_grant_d = sel;
                    we_d         = sel_we;
                    addr_d       = sel ? addr1 : addr0;
                    if (sel_we) begin
                        wdata_d = sel ? wdata1 : wdata0;
                    end
                    wen_d   = sel_we;
                    rstb_d  = ~sel_we;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (we_q) begin
                    state_d = StAck;
                end else begin
                    state_d    = StWait;
                    wait_cnt_d = 4'd1;
                end
            end
            StWait: begin
                if (wait_cnt_q == RdCnt) begin
                    if (grant_q) begin
                        rdata1_d = gb_rdata;
                    end else begin
                        rdata0_d = gb_rdata;
                    end
                    wait_cnt_d = 4'd0;
                    state_d    = StAck;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            wait_cnt_q   <= 4'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wen_q        <= 1'b0;
            rstb_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            wait_cnt_q   <= wait_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wen_q        <= wen_d;
            rstb_q       <= rstb_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign ack0     = (state_q == StAck) && !grant_q;
    assign ack1     = (state_q == StAck) && grant_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign gb_addr  = addr_q;
    assign gb_wdata = wdata_q;
    assign gb_wen   = wen_q;
    assign gb_rstb  = rstb_q;

`ifdef GB_ARBITER_STATS_EN
    logic [15:0] cnt0_q, cnt1_q;

    always_ff @(posedge gb_clk) begin
        if (gb_rst) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            if (ack0) cnt0_q <= cnt0_q + 16'd1;
            if (ack1) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`endif

endmodule
